cache_store: RTL

CACHE_STORE -- requirements
Module: cache_store

---
 rtl/cache_pkg.sv | 25 ++
 rtl/sat_counter.sv | 29 ++
 rtl/cache_store.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths, address slicing helpers and flush-FSM encoding for the
// direct-mapped cache store.
package cache_pkg;

  localparam int DEF_INDEX_W = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W - 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } flush_state_e;

  // Helpers take a widened address so any ADDR_W up to 64 can use them;
  // callers size-cast the result down to their own field width.
  function automatic logic [63:0] index_of(input logic [63:0] addr, input int unsigned index_w);
    return (addr >> 2) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] addr, input int unsigned index_w);
    return addr >> (index_w + 2);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 16-bit up counter that sticks at all-ones instead of wrapping.
module sat_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_store.sv
// Direct-mapped, one-word-per-line cache storage with zero-latency lookup,
// background flush sweep and saturating hit/miss statistics.
module cache_store
  import cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata_cpu,
  input  logic [DATA_W-1:0] rdata_ram,
  input  logic              update_tag,
  input  logic              update_cache,
  input  logic              flush,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  assign index = INDEX_W'(index_of(64'(addr), INDEX_W));
  assign tag   = TAG_W'(tag_of(64'(addr), INDEX_W));

  // Tag and data arrays carry no reset; only valid bits are cleared.
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  flush_state_e       state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic               req_prev_q, req_prev_d;
  logic               strobe_q, strobe_d;

  logic              req;
  logic              cache_en;
  logic              tag_we;
  logic              data_we;
  logic [DATA_W-1:0] data_wval;

  assign req      = read | write;
  assign cache_en = update_cache & req;
  assign busy     = (state_q == ST_SWEEP);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    tag_we    = 1'b0;
    data_we   = 1'b0;
    data_wval = wdata_cpu;
    case (state_q)
      ST_IDLE: begin
        // A fresh tag invalidates the line unless the fill lands on the same edge.
        if (update_tag) begin
          tag_we         = 1'b1;
          valid_d[index] = cache_en;
        end else if (cache_en && read) begin
          valid_d[index] = 1'b1;
        end
        if (cache_en) begin
          data_we   = 1'b1;
          data_wval = read ? rdata_ram : wdata_cpu;
        end
        if (flush && !req) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        valid_d[ptr_q] = 1'b0;
        ptr_d          = ptr_q + INDEX_W'(1);
        if (ptr_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A lookup is counted one edge after the request rises.
  assign req_prev_d = req;
  assign strobe_d   = req & ~req_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      ptr_q      <= '0;
      req_prev_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      req_prev_q <= req_prev_d;
      strobe_q   <= strobe_d;
    end
  end

  always_ff @(posedge clock) begin
    if (tag_we) begin
      tag_q[index] <= tag;
    end
    if (data_we) begin
      data_q[index] <= data_wval;
    end
  end

  assign hit   = valid_q[index] && (tag_q[index] == tag) && !busy;
  assign rdata = data_q[index];

  sat_counter u_hit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (strobe_q & hit),
    .count (hit_count)
  );

  sat_counter u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (strobe_q & ~hit),
    .count (miss_count)
  );

endmodule
